// File: rtl/recovery_pkg.sv
// recovery_pkg: shared fetch FSM encoding and recovery ROM layout constants.
package recovery_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;
  localparam logic [31:0] RECOVERY_BASE_ADDR  = 32'h0000_0000;
  localparam int          RECOVERY_CODE_WORDS = 16;
endpackage

// File: rtl/recovery_fetch_fifo.sv
// recovery_fetch_fifo: small flushable FIFO buffering fetched {addr, data} words.
module recovery_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
  assign rdata_o = mem_q[rd_q];
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/recovery_rom_fetcher.sv
// recovery_rom_fetcher: streams the recovery code sequence from ROM to the core
// instruction port through a credit-controlled FIFO.
module recovery_rom_fetcher import recovery_pkg::*; #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(RECOVERY_BASE_ADDR),
  parameter int                    CODE_WORDS = RECOVERY_CODE_WORDS,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  rom_req_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_rdata_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o
);
  localparam int NW = $clog2(CODE_WORDS+1);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  fetch_state_t          state_q;
  logic [NW-1:0]         issue_cnt_q, pop_cnt_q;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] addr_q, rsp_addr_q;
  logic                  push, pop, flush, full, empty, credit;
  logic [CW-1:0]         fifo_cnt;
  recovery_fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ADDR_WIDTH+DATA_WIDTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i ({rsp_addr_q, rom_rdata_i}),
    .rdata_o ({instr_addr_o, instr_rdata_o}),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_cnt)
  );
  assign pop           = !empty && instr_ready_i;
  assign push          = inflight_q && !abort_i;
  assign flush         = abort_i && state_q != IDLE;
  // A word leaving this cycle frees its slot for a request issued now.
  assign credit        = pop || (!full && !(inflight_q && fifo_cnt == CW'(FIFO_DEPTH-1)));
  assign rom_req_o     = state_q == FETCH && issue_cnt_q < NW'(CODE_WORDS) && credit && !abort_i;
  assign rom_addr_o    = addr_q;
  assign instr_valid_o = !empty;
  assign busy_o        = state_q != IDLE;
  assign done_o        = state_q == DRAIN && pop && pop_cnt_q == NW'(CODE_WORDS-1) && !abort_i;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      pop_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      addr_q      <= '0;
      rsp_addr_q  <= '0;
    end else begin
      inflight_q <= rom_req_o;
      if (rom_req_o) begin
        rsp_addr_q  <= addr_q;
        addr_q      <= addr_q + ADDR_WIDTH'(4);
        issue_cnt_q <= issue_cnt_q + 1'b1;
      end
      if (pop && !abort_i) pop_cnt_q <= pop_cnt_q + 1'b1;
      case (state_q)
        IDLE: if (start_i) begin
          state_q     <= FETCH;
          issue_cnt_q <= '0;
          pop_cnt_q   <= '0;
          addr_q      <= BASE_ADDR;
        end
        FETCH:   state_q <= abort_i ? IDLE : issue_cnt_q == NW'(CODE_WORDS) ? DRAIN : FETCH;
        DRAIN:   state_q <= (abort_i || done_o) ? IDLE : DRAIN;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
